mem_store_forward_buffer: RTL

- Forwards writeback data to the store-data operand of a store instruction in the MEM stage.
- Extends single-source WB->MEM forwarding with a DEPTH-entry history of recently retired register writes.
- A store held in MEM by a stall still receives the value of a producer that has already left WB.
- Sits between the EX/MEM and MEM/WB pipeline registers, in front of the data-memory write port; carries a saturating forward-event counter for performance analysis.

---
 rtl/mem_store_forward_buffer_pkg.sv | 23 ++
 rtl/mem_store_forward_buffer_if.sv | 37 +++
 rtl/mem_store_forward_buffer_wb_history_buffer.sv | 41 ++++
 rtl/mem_store_forward_buffer.sv | 91 +++++++++
 4 files changed

// File: rtl/mem_store_forward_buffer_pkg.sv
// Shared pipeline-forwarding definitions: default widths, special register
// numbers and the writeback-source encodings used upstream of this block.
package pipe_fwd_pkg;

    localparam int REG_W_DEFAULT  = 5;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic [4:0] LINK_REG = 5'd31;

    // Selects the writeback value in MEM/WB; decoded before reaching this block.
    typedef enum logic [1:0] {
        MEM_TO_REG_ALU = 2'b00,
        MEM_TO_REG_MEM = 2'b01,
        MEM_TO_REG_PC4 = 2'b10,
        MEM_TO_REG_ALT = 2'b11
    } mem_to_reg_e;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_store_forward_buffer_if.sv
// Bundles the EX/MEM store operands, the MEM/WB writeback and the forwarding
// results of the store-data forwarding buffer.
interface mem_store_forward_buffer_if
    import pipe_fwd_pkg::*;
#(
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = sel_width(DEPTH);

    logic              i_flush;
    logic [REG_W-1:0]  i_EX_MEM_Rt;
    logic              i_EX_MEM_mem_write;
    logic [DATA_W-1:0] i_EX_MEM_store_data;
    logic              i_MEM_WB_reg_write;
    logic [REG_W-1:0]  i_MEM_WB_wr_addr;
    logic [DATA_W-1:0] i_MEM_WB_wr_data;
    logic [DATA_W-1:0] o_store_data;
    logic              o_forward;
    logic [SEL_W-1:0]  o_forward_sel;
    logic [CNT_W-1:0]  o_fwd_count;

    modport master (
        output i_flush, i_EX_MEM_Rt, i_EX_MEM_mem_write, i_EX_MEM_store_data,
               i_MEM_WB_reg_write, i_MEM_WB_wr_addr, i_MEM_WB_wr_data,
        input  o_store_data, o_forward, o_forward_sel, o_fwd_count
    );

    modport slave (
        input  i_flush, i_EX_MEM_Rt, i_EX_MEM_mem_write, i_EX_MEM_store_data,
               i_MEM_WB_reg_write, i_MEM_WB_wr_addr, i_MEM_WB_wr_data,
        output o_store_data, o_forward, o_forward_sel, o_fwd_count
    );

endinterface

// File: rtl/mem_store_forward_buffer_wb_history_buffer.sv
// Shift register of the most recent retired register writes. Entry k occupies
// slot k-1 of the flat vectors, so slot 0 always holds the youngest write.
module wb_history_buffer
    import pipe_fwd_pkg::*;
#(
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [REG_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]       push_data,
    output logic [DEPTH-1:0]        valid,
    output logic [DEPTH*REG_W-1:0]  addr,
    output logic [DEPTH*DATA_W-1:0] data
);

    // Flush only drops valid bits; stale addr/data are unreachable once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            addr  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (push) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid[k]                  <= valid[k-1];
                addr[k*REG_W +: REG_W]    <= addr[(k-1)*REG_W +: REG_W];
                data[k*DATA_W +: DATA_W]  <= data[(k-1)*DATA_W +: DATA_W];
            end
            valid[0]          <= 1'b1;
            addr[0 +: REG_W]  <= push_addr;
            data[0 +: DATA_W] <= push_data;
        end
    end

endmodule

// File: rtl/mem_store_forward_buffer.sv
// Store-data forwarding for the MEM stage: live WB bypass backed by a short
// history of retired writes, plus a saturating forward-event counter.
module mem_store_forward_buffer
    import pipe_fwd_pkg::*;
#(
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    mem_store_forward_buffer_if.slave  bus
);

    localparam int SEL_W = sel_width(DEPTH);

    logic [DEPTH-1:0]        hist_valid;
    logic [DEPTH*REG_W-1:0]  hist_addr;
    logic [DEPTH*DATA_W-1:0] hist_data;

    logic              push;
    logic              store_active;
    logic              live_match;
    logic              forward;
    logic [SEL_W-1:0]  forward_sel;
    logic [DATA_W-1:0] store_data;
    logic [CNT_W-1:0]  fwd_count;

    assign push = bus.i_MEM_WB_reg_write &&
                  (bus.i_MEM_WB_wr_addr != REG_W'(ZERO_REG));

    wb_history_buffer #(
        .REG_W  (REG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_history (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (bus.i_flush),
        .push      (push),
        .push_addr (bus.i_MEM_WB_wr_addr),
        .push_data (bus.i_MEM_WB_wr_data),
        .valid     (hist_valid),
        .addr      (hist_addr),
        .data      (hist_data)
    );

    // A nonzero Rt makes the live-path zero-register check implicit.
    assign store_active = bus.i_EX_MEM_mem_write &&
                          (bus.i_EX_MEM_Rt != REG_W'(ZERO_REG));
    assign live_match   = bus.i_MEM_WB_reg_write &&
                          (bus.i_MEM_WB_wr_addr == bus.i_EX_MEM_Rt);

    // Oldest-to-youngest scan so the youngest matching entry is assigned last.
    always_comb begin
        forward     = 1'b0;
        forward_sel = '0;
        store_data  = bus.i_EX_MEM_store_data;
        if (store_active) begin
            if (live_match) begin
                forward    = 1'b1;
                store_data = bus.i_MEM_WB_wr_data;
            end else begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (hist_valid[k] &&
                        (hist_addr[k*REG_W +: REG_W] == bus.i_EX_MEM_Rt)) begin
                        forward     = 1'b1;
                        forward_sel = SEL_W'(k + 1);
                        store_data  = hist_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fwd_count <= '0;
        end else if (forward && (fwd_count != {CNT_W{1'b1}})) begin
            fwd_count <= fwd_count + CNT_W'(1);
        end
    end

    assign bus.o_store_data  = store_data;
    assign bus.o_forward     = forward;
    assign bus.o_forward_sel = forward_sel;
    assign bus.o_fwd_count   = fwd_count;

endmodule
